// File: rtl/btn_long_press_reset_if.sv
// Button front-end signal bundle: raw pad and arm control in, debounced level,
// press-classification pulses and the latched bootloader reset request out.
interface btn_long_press_reset_if;
  logic BTN_N;
  logic ARM;
  logic BTN_PRESSED;
  logic SHORT_PRESS;
  logic LONG_PRESS;
  logic RST_N;

  modport master (
    output BTN_N, ARM,
    input  BTN_PRESSED, SHORT_PRESS, LONG_PRESS, RST_N
  );

  modport slave (
    input  BTN_N, ARM,
    output BTN_PRESSED, SHORT_PRESS, LONG_PRESS, RST_N
  );
endinterface

// File: rtl/btn_long_press_reset.sv
// Synchronises and debounces the active-low button, classifies presses as short
// or long, and latches a bootloader reset request on an armed long press.
module btn_long_press_reset #(
  parameter int unsigned SYNC_STAGES       = 2,
  parameter int unsigned DEBOUNCE_CYCLES   = 480000,
  parameter int unsigned LONG_PRESS_CYCLES = 96000000
) (
  input  logic                   CLK,
  input  logic                   RST,
  btn_long_press_reset_if.slave  bus
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HELD, LONG} state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [DB_W-1:0]        r_db_cnt;
  logic [HOLD_W-1:0]      r_hold_cnt;
  logic                   r_pressed;
  logic                   r_short;
  logic                   r_long;
  logic                   r_rst_n;
  state_t                 r_state;

  logic w_s_pressed;
  logic w_differs;
  logic w_toggle;
  logic w_pressed_nxt;

  assign w_s_pressed   = ~r_sync[SYNC_STAGES-1];
  assign w_differs     = w_s_pressed ^ r_pressed;
  assign w_toggle      = w_differs && (r_db_cnt == DB_LAST);
  assign w_pressed_nxt = r_pressed ^ w_toggle;

  // Metastability synchroniser; resets to the released level.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.BTN_N};
    end
  end

  // Accept a level change only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pressed <= 1'b0;
      r_db_cnt  <= '0;
    end else if (!w_differs) begin
      r_db_cnt  <= '0;
    end else if (w_toggle) begin
      r_pressed <= ~r_pressed;
      r_db_cnt  <= '0;
    end else begin
      r_db_cnt  <= r_db_cnt + DB_W'(1);
    end
  end

  // Press classifier. Entry uses the registered level so the long pulse lands
  // LONG_PRESS_CYCLES after BTN_PRESSED rises; release uses the next level so
  // SHORT_PRESS coincides with the falling BTN_PRESSED edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= IDLE;
      r_hold_cnt <= '0;
      r_short    <= 1'b0;
      r_long     <= 1'b0;
      r_rst_n    <= 1'b1;
    end else begin
      r_short <= 1'b0;
      r_long  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_pressed) begin
            r_state    <= HELD;
            r_hold_cnt <= HOLD_W'(1);
          end else begin
            r_hold_cnt <= '0;
          end
        end
        HELD: begin
          // Completion wins over a release on the same edge.
          if (r_hold_cnt == HOLD_LAST) begin
            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
            r_long     <= 1'b1;
            r_state    <= LONG;
            if (bus.ARM) begin
              r_rst_n <= 1'b0;
            end
          end else if (!w_pressed_nxt) begin
            r_short    <= 1'b1;
            r_state    <= IDLE;
            r_hold_cnt <= '0;
          end else begin
            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
          end
        end
        LONG: begin
          if (!w_pressed_nxt) begin
            r_state    <= IDLE;
            r_hold_cnt <= '0;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_hold_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.BTN_PRESSED = r_pressed;
  assign bus.SHORT_PRESS = r_short;
  assign bus.LONG_PRESS  = r_long;
  assign bus.RST_N       = r_rst_n;

endmodule

// File: tb/tb_btn_long_press_reset.sv
// Event-scoreboard bench for btn_long_press_reset: expected output events with
// their edge numbers are queued as stimulus is driven and matched as they occur.
module tb_btn_long_press_reset;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int LNG  = 20;
  localparam int LAT  = SYNC + DEB - 1;

  localparam int EV_RISE      = 0;
  localparam int EV_FALL      = 1;
  localparam int EV_SHORT     = 2;
  localparam int EV_LONG      = 3;
  localparam int EV_RSTN_FALL = 4;
  localparam int EV_RSTN_RISE = 5;

  typedef struct {
    int kind;
    int at;
  } exp_t;

  logic CLK;
  logic RST;
  btn_long_press_reset_if bif ();

  btn_long_press_reset #(
    .SYNC_STAGES      (SYNC),
    .DEBOUNCE_CYCLES  (DEB),
    .LONG_PRESS_CYCLES(LNG)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bif)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;
  int   edge_n   = 0;
  bit   mon_en   = 1'b0;
  logic p_pressed;
  logic p_rstn;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fails++;
      $display("FAIL %s: observed %0d, expected %0d (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  task automatic expect_ev(input int kind, input int at);
    exp_t e;
    e.kind = kind;
    e.at   = at;
    sb_q.push_back(e);
  endtask

  task automatic note(input int kind);
    exp_t e;
    check_eq($sformatf("sb_has_entry_kind%0d", kind), int'(sb_q.size() != 0), 1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check_eq("evt_kind", kind, e.kind);
      check_eq($sformatf("evt_edge_kind%0d", kind), edge_n, e.at);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    edge_n++;
    if (mon_en) begin
      if (bif.BTN_PRESSED && !p_pressed) note(EV_RISE);
      if (!bif.BTN_PRESSED && p_pressed) note(EV_FALL);
      if (bif.SHORT_PRESS)               note(EV_SHORT);
      if (bif.LONG_PRESS)                note(EV_LONG);
      if (!bif.RST_N && p_rstn)          note(EV_RSTN_FALL);
      if (bif.RST_N && !p_rstn)          note(EV_RSTN_RISE);
      check_eq("short_long_excl", int'(bif.SHORT_PRESS & bif.LONG_PRESS), 0);
    end
    p_pressed = bif.BTN_PRESSED;
    p_rstn    = bif.RST_N;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int p;
    int r;
    RST       = 1'b1;
    bif.BTN_N = 1'b1;
    bif.ARM   = 1'b1;
    steps(3);
    RST = 1'b0;

    // Reset state
    check_eq("rst_btn_pressed", int'(bif.BTN_PRESSED), 0);
    check_eq("rst_short",       int'(bif.SHORT_PRESS), 0);
    check_eq("rst_long",        int'(bif.LONG_PRESS),  0);
    check_eq("rst_rst_n",       int'(bif.RST_N),       1);
    p_pressed = 1'b0;
    p_rstn    = 1'b1;
    mon_en    = 1'b1;

    // 1: idle released button, no events
    steps(50);
    check_eq("s1_sb_empty", sb_q.size(), 0);

    // 2: short press, armed
    bif.ARM   = 1'b1;
    bif.BTN_N = 1'b0;
    expect_ev(EV_RISE, edge_n + 1 + LAT);
    steps(10);
    bif.BTN_N = 1'b1;
    expect_ev(EV_FALL,  edge_n + 1 + LAT);
    expect_ev(EV_SHORT, edge_n + 1 + LAT);
    steps(20);
    check_eq("s2_sb_empty", sb_q.size(), 0);
    check_eq("s2_rst_n", int'(bif.RST_N), 1);

    // 3: bounce shorter than the debounce window
    for (int k = 0; k < 5; k++) begin
      bif.BTN_N = 1'b0;
      steps(3);
      bif.BTN_N = 1'b1;
      steps(2);
    end
    steps(20);
    check_eq("s3_sb_empty", sb_q.size(), 0);
    check_eq("s3_btn_pressed", int'(bif.BTN_PRESSED), 0);

    // 4: armed long press latches RST_N low until reset
    bif.ARM   = 1'b1;
    bif.BTN_N = 1'b0;
    p = edge_n + 1 + LAT;
    expect_ev(EV_RISE,      p);
    expect_ev(EV_LONG,      p + LNG);
    expect_ev(EV_RSTN_FALL, p + LNG);
    steps(40);
    bif.BTN_N = 1'b1;
    expect_ev(EV_FALL, edge_n + 1 + LAT);
    steps(20);
    check_eq("s4_rst_n_latched", int'(bif.RST_N), 0);
    expect_ev(EV_RSTN_RISE, edge_n + 1);
    RST = 1'b1;
    step();
    RST = 1'b0;
    steps(5);
    check_eq("s4_sb_empty", sb_q.size(), 0);
    check_eq("s4_rst_n_released", int'(bif.RST_N), 1);

    // 5: unarmed long press, later arming has no effect
    bif.ARM   = 1'b0;
    bif.BTN_N = 1'b0;
    p = edge_n + 1 + LAT;
    expect_ev(EV_RISE, p);
    expect_ev(EV_LONG, p + LNG);
    steps(40);
    bif.BTN_N = 1'b1;
    expect_ev(EV_FALL, edge_n + 1 + LAT);
    steps(20);
    bif.ARM = 1'b1;
    steps(10);
    check_eq("s5_sb_empty", sb_q.size(), 0);
    check_eq("s5_rst_n", int'(bif.RST_N), 1);

    // 6: reset during a held press, button kept low
    bif.ARM   = 1'b0;
    bif.BTN_N = 1'b0;
    p = edge_n + 1 + LAT;
    expect_ev(EV_RISE, p);
    while (edge_n < p + 9) step();
    r = edge_n + 1;
    expect_ev(EV_FALL, r);
    RST = 1'b1;
    step();
    RST = 1'b0;
    p = r + 1 + LAT;
    expect_ev(EV_RISE, p);
    expect_ev(EV_LONG, p + LNG);
    while (edge_n < p + LNG + 5) step();
    bif.BTN_N = 1'b1;
    expect_ev(EV_FALL, edge_n + 1 + LAT);
    steps(15);
    check_eq("s6_sb_empty", sb_q.size(), 0);
    check_eq("s6_rst_n", int'(bif.RST_N), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
